// File: rtl/rotary_encoder_if.sv
// Encoder-side bundle: debounced quadrature inputs in, value and event pulses out.
// The master side drives the contacts; the slave side is the decoder.
interface rotary_encoder_if #(
    parameter int WIDTH = 8
);
    logic             a;
    logic             b;
    logic [WIDTH-1:0] value;
    logic             up;
    logic             down;
    logic             error;

    modport master (
        output a,
        output b,
        input  value,
        input  up,
        input  down,
        input  error
    );

    modport slave (
        input  a,
        input  b,
        output value,
        output up,
        output down,
        output error
    );
endinterface

// File: rtl/rotary_encoder.sv
// Quadrature decoder: turns debounced A/B Gray-code transitions into detent steps,
// a wrapping or saturating value, and one-cycle up/down/error pulses.
module rotary_encoder #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int PER_STEP   = 4,
    parameter bit SATURATE   = 1'b0,
    parameter int INIT_VALUE = 0
) (
    input logic             clk,
    input logic             reset,
    rotary_encoder_if.slave enc
);

    localparam int ACC_W = 4;
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] PER_POS = ACC_W'(PER_STEP);
    localparam logic signed [ACC_W-1:0] PER_NEG = -PER_POS;

    // Encoding equals the Gray-position difference modulo 4, so classification is a subtract.
    typedef enum logic [1:0] {
        MOVE_IDLE    = 2'd0,
        MOVE_FWD     = 2'd1,
        MOVE_ILLEGAL = 2'd2,
        MOVE_REV     = 2'd3
    } move_e;

    logic [1:0]              ab_q, ab_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic                    up_q, up_d;
    logic                    down_q, down_d;
    logic                    error_q, error_d;

    logic [1:0]              cur;
    move_e                   move;
    logic signed [ACC_W-1:0] acc_inc;
    logic signed [ACC_W-1:0] acc_dec;

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic move_e classify(input logic [1:0] prev, input logic [1:0] now);
        logic [1:0] diff;
        diff = gray_pos(now) - gray_pos(prev);
        return move_e'(diff);
    endfunction

    // One extra bit exposes the carry/borrow used for clamping.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v,
                                                    input logic dir_up);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] stp;
        logic [WIDTH:0] res;
        ext = {1'b0, v};
        stp = (WIDTH+1)'(STEP);
        if (dir_up) begin
            res = ext + stp;
            if (SATURATE && res[WIDTH]) begin
                return '1;
            end
        end else begin
            res = ext - stp;
            if (SATURATE && res[WIDTH]) begin
                return '0;
            end
        end
        return res[WIDTH-1:0];
    endfunction

    assign cur     = {enc.a, enc.b};
    assign move    = classify(ab_q, cur);
    assign acc_inc = acc_q + ACC_ONE;
    assign acc_dec = acc_q - ACC_ONE;

    always_comb begin
        ab_d    = cur;
        acc_d   = acc_q;
        value_d = value_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        error_d = 1'b0;
        case (move)
            MOVE_FWD: begin
                if (acc_inc == PER_POS) begin
                    acc_d   = '0;
                    up_d    = 1'b1;
                    value_d = step_value(value_q, 1'b1);
                end else begin
                    acc_d = acc_inc;
                end
            end
            MOVE_REV: begin
                if (acc_dec == PER_NEG) begin
                    acc_d   = '0;
                    down_d  = 1'b1;
                    value_d = step_value(value_q, 1'b0);
                end else begin
                    acc_d = acc_dec;
                end
            end
            MOVE_ILLEGAL: begin
                acc_d   = '0;
                error_d = 1'b1;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Reset captures the live inputs so release never looks like a transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ab_q    <= cur;
            acc_q   <= '0;
            value_q <= WIDTH'(INIT_VALUE);
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ab_q    <= ab_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            up_q    <= up_d;
            down_q  <= down_d;
            error_q <= error_d;
        end
    end

    assign enc.value = value_q;
    assign enc.up    = up_q;
    assign enc.down  = down_q;
    assign enc.error = error_q;

endmodule

// File: tb/tb_rotary_encoder.sv
// Scoreboard bench: three decoder configurations share one A/B stream; a rule-level
// model queues expected pulses and a negedge monitor matches them against the outputs.
module tb_rotary_encoder;

    localparam int N = 3;
    localparam int W = 8;
    localparam int STEP_P [N] = '{1, 1, 3};
    localparam int PER_P  [N] = '{4, 4, 2};
    localparam int SAT_P  [N] = '{0, 1, 1};
    localparam int INIT_P [N] = '{0, 255, 5};

    localparam int K_NONE  = 0;
    localparam int K_UP    = 1;
    localparam int K_DOWN  = 2;
    localparam int K_ERR   = 3;
    localparam int K_MULTI = 4;

    typedef struct {
        int cyc;
        int inst;
        int kind;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic a_drv;
    logic b_drv;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ev_t  sbq[$];
    ev_t  e;
    int   ek  [N];
    int   evl [N];
    int   acc [N];
    int   mv  [N];
    logic [1:0] prev;

    rotary_encoder_if #(.WIDTH(W)) if0 ();
    rotary_encoder_if #(.WIDTH(W)) if1 ();
    rotary_encoder_if #(.WIDTH(W)) if2 ();

    assign if0.a = a_drv;
    assign if0.b = b_drv;
    assign if1.a = a_drv;
    assign if1.b = b_drv;
    assign if2.a = a_drv;
    assign if2.b = b_drv;

    rotary_encoder #(.WIDTH(W), .STEP(1), .PER_STEP(4), .SATURATE(1'b0), .INIT_VALUE(0))
        dut0 (.clk(clk), .reset(reset), .enc(if0));
    rotary_encoder #(.WIDTH(W), .STEP(1), .PER_STEP(4), .SATURATE(1'b1), .INIT_VALUE(255))
        dut1 (.clk(clk), .reset(reset), .enc(if1));
    rotary_encoder #(.WIDTH(W), .STEP(3), .PER_STEP(2), .SATURATE(1'b1), .INIT_VALUE(5))
        dut2 (.clk(clk), .reset(reset), .enc(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int get_val(input int i);
        case (i)
            0:       return int'(if0.value);
            1:       return int'(if1.value);
            default: return int'(if2.value);
        endcase
    endfunction

    function automatic int pulse_kind(input logic u, input logic d, input logic er);
        int n;
        n = 0;
        if (u === 1'b1) n++;
        if (d === 1'b1) n++;
        if (er === 1'b1) n++;
        if (n > 1) return K_MULTI;
        if (u === 1'b1) return K_UP;
        if (d === 1'b1) return K_DOWN;
        if (er === 1'b1) return K_ERR;
        return K_NONE;
    endfunction

    function automatic int get_kind(input int i);
        case (i)
            0:       return pulse_kind(if0.up, if0.down, if0.error);
            1:       return pulse_kind(if1.up, if1.down, if1.error);
            default: return pulse_kind(if2.up, if2.down, if2.error);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input int kind);
        ev_t ev;
        ev.cyc  = cyc + 1;
        ev.inst = i;
        ev.kind = kind;
        ev.val  = mv[i];
        sbq.push_back(ev);
    endtask

    // Rule-level model: successor tables decide direction, plain ints hold acc and value.
    task automatic model(input logic [1:0] now, input logic rn);
        int n;
        for (int i = 0; i < N; i++) begin
            if (!rn) begin
                acc[i] = 0;
                mv[i]  = INIT_P[i];
            end else if (now == prev) begin
                acc[i] = acc[i];
            end else if (now == cw_next(prev)) begin
                acc[i] = acc[i] + 1;
                if (acc[i] == PER_P[i]) begin
                    acc[i] = 0;
                    n = mv[i] + STEP_P[i];
                    if (n > 255) n = (SAT_P[i] != 0) ? 255 : n - 256;
                    mv[i] = n;
                    push(i, K_UP);
                end
            end else if (now == ccw_next(prev)) begin
                acc[i] = acc[i] - 1;
                if (acc[i] == -PER_P[i]) begin
                    acc[i] = 0;
                    n = mv[i] - STEP_P[i];
                    if (n < 0) n = (SAT_P[i] != 0) ? 0 : n + 256;
                    mv[i] = n;
                    push(i, K_DOWN);
                end
            end else begin
                acc[i] = 0;
                push(i, K_ERR);
            end
        end
        prev = now;
    endtask

    task automatic tick(input logic na, input logic nb, input logic rn);
        a_drv = na;
        b_drv = nb;
        reset = rn;
        model({na, nb}, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) tick(a_drv, b_drv, 1'b1);
    endtask

    task automatic move_to(input logic [1:0] ab);
        tick(ab[1], ab[0], 1'b1);
        hold(2);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        tick(ab[1], ab[0], 1'b0);
        tick(ab[1], ab[0], 1'b1);
    endtask

    task automatic check_model_vals(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_value_inst%0d", tag, i), get_val(i), mv[i]);
    endtask

    // Monitor: collect this cycle's expected pulses, compare whenever either side has one.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            ek[i]  = K_NONE;
            evl[i] = 0;
        end
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) check("stale_expectation", e.cyc, cyc);
            else begin
                ek[e.inst]  = e.kind;
                evl[e.inst] = e.val;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (get_kind(i) != K_NONE || ek[i] != K_NONE) begin
                check($sformatf("pulse_kind_inst%0d", i), get_kind(i), ek[i]);
                if (ek[i] != K_NONE && get_kind(i) == ek[i])
                    check($sformatf("pulse_value_inst%0d", i), get_val(i), evl[i]);
            end
        end
    end

    initial begin
        int r;
        int cw_pct;
        logic [1:0] c;
        prev = 2'b11;
        for (int i = 0; i < N; i++) begin
            acc[i] = 0;
            mv[i]  = INIT_P[i];
        end

        // Reset with inputs at 11, then hold: nothing should move.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        hold(3);
        check("reset_value_inst0", get_val(0), 0);
        check("reset_value_inst1", get_val(1), 255);
        check("reset_value_inst2", get_val(2), 5);

        // One CW detent from 00, one change every 3 clocks.
        do_reset(2'b00);
        move_to(2'b10);
        move_to(2'b11);
        move_to(2'b01);
        check("partial_detent_inst0", get_val(0), 0);
        move_to(2'b00);
        check("cw_detent_inst0", get_val(0), 1);
        check_model_vals("cw");

        // CCW detent: wrap to 0xFF, saturating copy goes 0xFF->0xFE.
        do_reset(2'b00);
        move_to(2'b01);
        move_to(2'b11);
        move_to(2'b10);
        move_to(2'b00);
        check("ccw_wrap_inst0", get_val(0), 255);
        check("ccw_sat_inst1", get_val(1), 254);
        check_model_vals("ccw");

        // Saturation at the top: CW holds at 0xFF, CCW then gives 0xFE.
        do_reset(2'b00);
        move_to(2'b10);
        move_to(2'b11);
        move_to(2'b01);
        move_to(2'b00);
        check("sat_hold_inst1", get_val(1), 255);
        move_to(2'b01);
        move_to(2'b11);
        move_to(2'b10);
        move_to(2'b00);
        check("sat_back_inst1", get_val(1), 254);

        // Illegal jumps clear the partial accumulator.
        do_reset(2'b00);
        move_to(2'b10);
        move_to(2'b11);
        move_to(2'b00);
        check("illegal_hold_inst0", get_val(0), 0);
        move_to(2'b10);
        move_to(2'b11);
        move_to(2'b01);
        move_to(2'b00);
        check("after_illegal_inst0", get_val(0), 1);
        move_to(2'b11);
        move_to(2'b01);
        move_to(2'b00);
        move_to(2'b10);
        move_to(2'b11);
        check("after_illegal2_inst0", get_val(0), 2);
        check_model_vals("illegal");

        // Jitter, then a partial detent discarded by reset.
        do_reset(2'b00);
        move_to(2'b10);
        move_to(2'b00);
        move_to(2'b10);
        move_to(2'b00);
        check("jitter_inst0", get_val(0), 0);
        move_to(2'b10);
        move_to(2'b11);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        move_to(2'b01);
        move_to(2'b00);
        move_to(2'b10);
        move_to(2'b11);
        check("reset_mid_inst0", get_val(0), 1);
        check_model_vals("reset_mid");

        // Randomized walk: CW-biased first half, CCW-biased second half.
        for (int k = 0; k < 3000; k++) begin
            c = {a_drv, b_drv};
            cw_pct = (k < 1500) ? 70 : 15;
            r = int'($urandom_range(0, 999));
            if (r < 3) tick(c[1], c[0], 1'b0);
            else if (r < 40) tick(~c[1], ~c[0], 1'b1);
            else begin
                r = int'($urandom_range(0, 99));
                if (r < cw_pct) begin
                    c = cw_next(c);
                    tick(c[1], c[0], 1'b1);
                end else if (r < 85) begin
                    c = ccw_next(c);
                    tick(c[1], c[0], 1'b1);
                end else begin
                    hold(1);
                end
            end
            if (k % 100 == 99) check_model_vals("random");
        end

        hold(3);
        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
